chess_clock_multi: RTL and testbench
====================================

// Module: chess_clock_multi
// PURPOSE
//  N-player chess game clock for the game_play subsystem. Keeps an independent
//  countdown timer per player in centiseconds and decrements only the active
//  player's timer. Adds a Fischer increment on each completed move, then hands
//  the turn to the next player. Flags the first timer to expire and outputs the
//  selected player's time as BCD MM:SS:cc digits for the hex displays.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency
//  TICK_HZ      100         decrement rate (1 tick = 1 cs)
//  NUM_PLAYERS  2           number of timers, >=2
//  TW           19          timer width; holds MAX_CS = 359999 (59:59.99)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  load       in   1       pulse: preset all timers, enter READY
//  mode_sel   in   2       base time: 0=1min 1=3min 2=10min 3=30min
//  inc_sel    in   2       increment: 0=0s 1=1s 2=2s 3=5s (sampled on load)
//  start      in   1       pulse: READY/PAUSED -> RUN
//  pause      in   1       pulse: RUN -> PAUSED
//  move_done  in   1       pulse: active player has completed a move
//  disp_sel   in   PW      player shown on BCD outputs, PW=$clog2(NUM_PLAYERS)
//  active     out  PW      player whose timer is running
//  running    out  1       1 while state==RUN
//  game_over  out  1       1 while state==OVER
//  flag       out  N       per-player expiry flag, one-hot or zero
//  min_t,min_u,sec_t,sec_u,cs_t,cs_u  out 4 each  BCD digits of timer[disp_sel]
// BEHAVIOUR
//  States: IDLE, READY, RUN, PAUSED, OVER. Reset -> IDLE, timers=0, active=0,
//   flag=0, divider=0, inc_reg=0; running=0, game_over=0, all BCD digits 0.
//  Event priority within one cycle: reset > load > tick/expiry > move_done > pause > start.
//  load (any state): every timer <= base(mode_sel), inc_reg <= inc(inc_sel),
//   active<=0, flag<=0, divider<=0, state<=READY. All other inputs are ignored
//   that cycle.
//  IDLE: waits for load only; start/pause/move_done are ignored.
//  READY: start -> RUN. PAUSED: start -> RUN, pause ignored. Divider holds its
//   value in READY/PAUSED, so the partial tick resumes after a restart.
//  RUN: divider counts 0..CLK_FREQ_HZ/TICK_HZ-1 and wraps. The wrap cycle is a
//   tick: timer[active] decrements by 1, visible the next cycle.
//  Expiry: a tick that takes timer[active] from 1 to 0 sets flag[active] and
//   state<=OVER in the same edge. A move_done in that same cycle is dropped
//   (flag wins). A timer never goes below 0.
//  move_done in RUN with no expiry: timer[active] <= min(timer+inc_reg, MAX_CS).
//   active <= (active==NUM_PLAYERS-1) ? 0 : active+1. divider<=0.
//   If a non-expiring tick falls in the same cycle, the result is
//   timer-1+inc_reg, saturated.
//  pause in RUN: state<=PAUSED. Timers and active are unchanged.
//  move_done outside RUN is ignored.
//  OVER: all inputs except load and reset are ignored. Timers and flag hold.
//  BCD digits are combinational from the timer[disp_sel] register:
//   cs = t%100, sec = (t/100)%60, min = t/6000. Zero added latency.
//  disp_sel >= NUM_PLAYERS displays 00:00:00.
//  Reset mid-RUN returns to IDLE immediately (asynchronous).
// TESTING (CLK_FREQ_HZ=1000, TICK_HZ=100 -> 10 clk per tick, NUM_PLAYERS=2)
//  reset, then load with mode_sel=0, inc_sel=0 -> both timers 6000, BCD 01:00:00,
//   state READY, active=0, flag=00.
//  start, then 25 clk -> timer0=5998, timer1=6000. pause, then 100 clk -> no change.
//  load with inc_sel=1, start, then move_done at timer0=5990 -> timer0=6090,
//   active=1, divider=0. Timer1 first decrements 10 clk later.
//  Force timer0=1, next tick -> flag=01, game_over=1. A move_done in the same
//   cycle leaves active=0. Later start/move_done have no effect.
//  mode_sel=3, inc_sel=3, timer0=359800, move_done -> timer0=359999 (saturated),
//   BCD 59:59.99.
//  Assert reset while RUN -> IDLE, all outputs 0. Then start without load -> stays IDLE.

Source files
------------

// File: rtl/chess_clock_multi.sv
// N-player chess clock: per-player centisecond countdown timers, Fischer increment,
// first-expiry flag and BCD MM:SS:cc readout of a selected player.

module chess_clock_timer #(
    parameter int TW = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] base,
    input  logic [TW-1:0] inc,
    input  logic          tick,
    input  logic          move,
    output logic [TW-1:0] t
);
    localparam logic [TW:0] MAX_CS = (TW+1)'(359999);

    logic [TW-1:0] dec;
    logic [TW:0]   sum;
    logic [TW-1:0] nxt;

    // A tick and a move in the same cycle combine as t-1+inc, saturated.
    always_comb begin
        dec = (tick && t != '0) ? t - 1'b1 : t;
        sum = {1'b0, dec} + {1'b0, inc};
        nxt = dec;
        if (move) nxt = (sum > MAX_CS) ? MAX_CS[TW-1:0] : sum[TW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             t <= '0;
        else if (load)         t <= base;
        else if (tick || move) t <= nxt;
    end
endmodule

module chess_clock_multi #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int NUM_PLAYERS = 2,
    parameter int TW          = 19,
    localparam int PW         = $clog2(NUM_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [1:0]             mode_sel,
    input  logic [1:0]             inc_sel,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   move_done,
    input  logic [PW-1:0]          disp_sel,
    output logic [PW-1:0]          active,
    output logic                   running,
    output logic                   game_over,
    output logic [NUM_PLAYERS-1:0] flag,
    output logic [3:0]             min_t,
    output logic [3:0]             min_u,
    output logic [3:0]             sec_t,
    output logic [3:0]             sec_u,
    output logic [3:0]             cs_t,
    output logic [3:0]             cs_u
);
    localparam int DIV_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READY, S_RUN, S_PAUSED, S_OVER} state_t;

    state_t                         state, state_n;
    logic [DIV_W-1:0]               div;
    logic [TW-1:0]                  inc_reg;
    logic [TW-1:0]                  base;
    logic [TW-1:0]                  inc_val;
    logic [NUM_PLAYERS-1:0][TW-1:0] times;
    logic [TW-1:0]                  t_act;
    logic [TW-1:0]                  t_sel;
    logic                           tick, expire, mv;

    always_comb begin
        case (mode_sel)
            2'd0:    base = TW'(6000);
            2'd1:    base = TW'(18000);
            2'd2:    base = TW'(60000);
            default: base = TW'(180000);
        endcase
        case (inc_sel)
            2'd0:    inc_val = TW'(0);
            2'd1:    inc_val = TW'(100);
            2'd2:    inc_val = TW'(200);
            default: inc_val = TW'(500);
        endcase
    end

    always_comb begin
        t_act = '0;
        t_sel = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (active == PW'(i))   t_act = times[i];
            if (disp_sel == PW'(i)) t_sel = times[i];
        end
    end

    // load overrides everything; expiry drops a coincident move.
    assign tick   = (state == S_RUN) && !load && (div == DIV_W'(DIV_MAX));
    assign expire = tick && (t_act == TW'(1));
    assign mv     = (state == S_RUN) && !load && move_done && !expire;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_pl
        chess_clock_timer #(.TW(TW)) u_tmr (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .base  (base),
            .inc   (inc_reg),
            .tick  (tick && active == PW'(i)),
            .move  (mv && active == PW'(i)),
            .t     (times[i])
        );
    end

    always_comb begin
        state_n = state;
        if (load) begin
            state_n = S_READY;
        end else begin
            case (state)
                S_READY, S_PAUSED: if (start) state_n = S_RUN;
                S_RUN: begin
                    if (expire)     state_n = S_OVER;
                    else if (!mv && pause) state_n = S_PAUSED;
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            div     <= '0;
            inc_reg <= '0;
            active  <= '0;
            flag    <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                div     <= '0;
                inc_reg <= inc_val;
                active  <= '0;
                flag    <= '0;
            end else if (state == S_RUN) begin
                div <= (tick || mv) ? '0 : div + 1'b1;
                if (expire) flag[active] <= 1'b1;
                if (mv) active <= (active == PW'(NUM_PLAYERS - 1)) ? '0 : active + 1'b1;
            end
        end
    end

    assign running   = (state == S_RUN);
    assign game_over = (state == S_OVER);

    logic [TW-1:0] mins, rem, secs, cs;
    always_comb begin
        mins  = t_sel / TW'(6000);
        rem   = t_sel % TW'(6000);
        secs  = rem / TW'(100);
        cs    = rem % TW'(100);
        min_t = 4'(mins / TW'(10));
        min_u = 4'(mins % TW'(10));
        sec_t = 4'(secs / TW'(10));
        sec_u = 4'(secs % TW'(10));
        cs_t  = 4'(cs / TW'(10));
        cs_u  = 4'(cs % TW'(10));
    end
endmodule

// File: tb/tb_chess_clock_multi.sv
// Directed bench for chess_clock_multi: a 10-clk-per-tick instance for timing and
// increment behaviour, and a 2-clk-per-tick instance to reach expiry quickly.
module tb_chess_clock_multi;
    logic clk = 0;
    logic reset;
    always #5 clk = ~clk;

    logic       load, start, pause, move_done, disp_sel;
    logic [1:0] mode_sel, inc_sel;
    logic       active, running, game_over;
    logic [1:0] flag;
    logic [3:0] min_t, min_u, sec_t, sec_u, cs_t, cs_u;
    logic [23:0] bcd;
    assign bcd = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};

    logic       f_load, f_start, f_pause, f_move, f_disp;
    logic       f_active, f_running, f_over;
    logic [1:0] f_flag;
    logic [3:0] f_d [6];
    logic [23:0] f_bcd;
    assign f_bcd = {f_d[0], f_d[1], f_d[2], f_d[3], f_d[4], f_d[5]};

    chess_clock_multi #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .NUM_PLAYERS(2), .TW(19)) dut (
        .clk(clk), .reset(reset), .load(load), .mode_sel(mode_sel), .inc_sel(inc_sel),
        .start(start), .pause(pause), .move_done(move_done), .disp_sel(disp_sel),
        .active(active), .running(running), .game_over(game_over), .flag(flag),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u), .cs_t(cs_t), .cs_u(cs_u)
    );

    chess_clock_multi #(.CLK_FREQ_HZ(200), .TICK_HZ(100), .NUM_PLAYERS(2), .TW(19)) u_fast (
        .clk(clk), .reset(reset), .load(f_load), .mode_sel(2'd0), .inc_sel(2'd0),
        .start(f_start), .pause(f_pause), .move_done(f_move), .disp_sel(f_disp),
        .active(f_active), .running(f_running), .game_over(f_over), .flag(f_flag),
        .min_t(f_d[0]), .min_u(f_d[1]), .sec_t(f_d[2]), .sec_u(f_d[3]), .cs_t(f_d[4]), .cs_u(f_d[5])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic see(input logic sel);
        disp_sel = sel;
        #1;
    endtask

    bit found;

    initial begin
        reset = 1; load = 0; start = 0; pause = 0; move_done = 0; disp_sel = 0;
        mode_sel = 0; inc_sel = 0;
        f_load = 0; f_start = 0; f_pause = 0; f_move = 0; f_disp = 0;
        cyc(3);
        chk("rst_active", active, 0);
        chk("rst_running", running, 0);
        chk("rst_over", game_over, 0);
        chk("rst_flag", flag, 0);
        chk("rst_bcd", bcd, 0);
        reset = 0;
        cyc(2);

        // load 1 min, no increment
        load = 1; cyc(1); load = 0;
        see(0); chk("load_bcd0", bcd, 24'h010000);
        see(1); chk("load_bcd1", bcd, 24'h010000);
        chk("load_running", running, 0);
        chk("load_active", active, 0);
        chk("load_flag", flag, 0);

        start = 1; cyc(1); start = 0;
        chk("start_running", running, 1);
        cyc(25);
        see(0); chk("run25_t0", bcd, 24'h005998);
        see(1); chk("run25_t1", bcd, 24'h010000);
        pause = 1; cyc(1); pause = 0;
        cyc(100);
        chk("pause_running", running, 0);
        see(0); chk("pause_t0", bcd, 24'h005998);

        // 1 s increment
        inc_sel = 1;
        load = 1; cyc(1); load = 0;
        start = 1; cyc(1); start = 0;
        cyc(100);
        see(0); chk("inc_t0_pre", bcd, 24'h005990);
        move_done = 1; cyc(1); move_done = 0;
        see(0); chk("inc_t0_post", bcd, 24'h010090);
        chk("inc_active", active, 1);
        cyc(9);
        see(1); chk("inc_t1_hold", bcd, 24'h010000);
        cyc(1);
        see(1); chk("inc_t1_dec", bcd, 24'h005999);
        see(0); chk("inc_t0_hold", bcd, 24'h010090);
        move_done = 1; cyc(1); move_done = 0;
        see(1); chk("inc_t1_move", bcd, 24'h010099);
        chk("inc_wrap_active", active, 0);

        // 30 min + 5 s, move every cycle so no tick ever lands
        mode_sel = 3; inc_sel = 3;
        load = 1; cyc(1); load = 0;
        see(0); chk("sat_load", bcd, 24'h300000);
        start = 1; cyc(1); start = 0;
        move_done = 1;
        cyc(718);
        see(0); chk("sat_t0_pre", bcd, 24'h595500);
        see(1); chk("sat_t1_pre", bcd, 24'h595500);
        chk("sat_active_pre", active, 0);
        cyc(1);
        move_done = 0;
        see(0); chk("sat_t0", bcd, 24'h595999);
        chk("sat_active", active, 1);

        // expiry on the fast instance, with a coincident move_done
        f_load = 1; cyc(1); f_load = 0;
        f_start = 1; cyc(1); f_start = 0;
        found = 0;
        for (int i = 0; i < 13000 && !found; i++) begin
            cyc(1);
            if (f_bcd == 24'h000001) found = 1;
        end
        chk("exp_reach_one", f_bcd, 24'h000001);
        chk("exp_not_over_yet", f_over, 0);
        cyc(1);
        f_move = 1; cyc(1); f_move = 0;
        chk("exp_flag", f_flag, 2'b01);
        chk("exp_over", f_over, 1);
        chk("exp_active", f_active, 0);
        chk("exp_bcd", f_bcd, 0);
        f_start = 1; cyc(1); f_start = 0;
        f_move = 1; cyc(1); f_move = 0;
        cyc(5);
        chk("over_active", f_active, 0);
        chk("over_running", f_running, 0);
        chk("over_flag", f_flag, 2'b01);
        f_disp = 1; #1;
        chk("over_t1", f_bcd, 24'h010000);

        // asynchronous reset mid-run
        chk("pre_rst_running", running, 1);
        reset = 1; #1;
        chk("arst_running", running, 0);
        chk("arst_active", active, 0);
        chk("arst_bcd", bcd, 0);
        chk("arst_f_over", f_over, 0);
        chk("arst_f_flag", f_flag, 0);
        cyc(1);
        reset = 0;
        cyc(1);
        start = 1; cyc(1); start = 0;
        move_done = 1; cyc(1); move_done = 0;
        cyc(20);
        chk("idle_running", running, 0);
        chk("idle_active", active, 0);
        chk("idle_bcd", bcd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
